// File: rtl/risc_mc_ctrl.sv
// Multicycle RISC control FSM: fetch, decode, ALU, load/store, branch, jump.
// Optional memory wait timeout enabled by defining RISC_MC_TIMEOUT_EN.
module risc_mc_ctrl #(
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 15,
   parameter int STATE_W  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         op,
   input  logic               compare,
   input  logic               mem_ready,
   output logic               pcen,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regwrite,
   output logic               alusrca,
   output logic               iord,
   output logic               memtoreg,
   output logic               regdst,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [1:0]         alucontrol,
   output logic               mem_req,
   output logic [STATE_W-1:0] state,
   output logic               illegal,
   output logic [CNT_W-1:0]   instret
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXEC_R = 4'd2,
      WB_R   = 4'd3,
      MEMADR = 4'd4,
      MEMRD  = 4'd5,
      MEMWB  = 4'd6,
      MEMWR  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      TRAP   = 4'd10
   } state_t;

   state_t cur, nxt;
   logic   retire;
   logic   trap_set;
   logic   req_raw;
   logic   wr_raw;
   logic   timeout;

`ifdef RISC_MC_TIMEOUT_EN
   localparam int WW = $clog2(WAIT_MAX + 1);
   logic [WW-1:0] wait_cnt;
   logic          waiting;

   assign waiting = (cur == FETCH || cur == MEMRD || cur == MEMWR) && !mem_ready;
   assign timeout = waiting && (wait_cnt == WW'(WAIT_MAX - 1));

   // Count stalled cycles of the current access; any state change restarts it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wait_cnt <= '0;
      else if (nxt != cur)
         wait_cnt <= '0;
      else if (waiting)
         wait_cnt <= wait_cnt + WW'(1);
   end
`else
   logic unused_wait_max;
   assign unused_wait_max = (WAIT_MAX != 0);
   assign timeout = 1'b0;
`endif

   // State, sticky illegal flag and retired-instruction counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur     <= FETCH;
         illegal <= 1'b0;
         instret <= '0;
      end else begin
         cur <= nxt;
         if (trap_set)
            illegal <= 1'b1;
         if (retire)
            instret <= instret + CNT_W'(1);
      end
   end

   // Next state and datapath controls decoded from the current state
   always_comb begin
      nxt        = cur;
      retire     = 1'b0;
      trap_set   = 1'b0;
      pcen       = 1'b0;
      wr_raw     = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 2'b00;
      req_raw    = 1'b0;
      case (cur)
         FETCH: begin
            req_raw = 1'b1;
            alusrcb = 2'b01;
            if (mem_ready) begin
               irwrite = 1'b1;
               pcen    = 1'b1;
               nxt     = DECODE;
            end else if (timeout) begin
               nxt      = TRAP;
               trap_set = 1'b1;
            end
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               4'b0000, 4'b0001, 4'b0010: nxt = EXEC_R;
               4'b0100, 4'b0101:          nxt = MEMADR;
               4'b1000:                   nxt = BRANCH;
               4'b1001:                   nxt = JUMP;
               default: begin
                  nxt      = TRAP;
                  trap_set = 1'b1;
               end
            endcase
         end
         EXEC_R: begin
            alusrca    = 1'b1;
            alucontrol = op[1:0];
            nxt        = WB_R;
         end
         WB_R: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            retire   = 1'b1;
            nxt      = FETCH;
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            nxt     = (op == 4'b0101) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            req_raw = 1'b1;
            iord    = 1'b1;
            if (mem_ready)
               nxt = MEMWB;
            else if (timeout) begin
               nxt      = TRAP;
               trap_set = 1'b1;
            end
         end
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            retire   = 1'b1;
            nxt      = FETCH;
         end
         MEMWR: begin
            req_raw = 1'b1;
            iord    = 1'b1;
            wr_raw  = 1'b1;
            if (mem_ready) begin
               retire = 1'b1;
               nxt    = FETCH;
            end else if (timeout) begin
               nxt      = TRAP;
               trap_set = 1'b1;
            end
         end
         BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = 2'b01;
            pcsrc      = 2'b01;
            pcen       = compare;
            retire     = 1'b1;
            nxt        = FETCH;
         end
         JUMP: begin
            pcsrc  = 2'b10;
            pcen   = 1'b1;
            retire = 1'b1;
            nxt    = FETCH;
         end
         TRAP:    nxt = TRAP;
         default: nxt = FETCH;
      endcase
   end

   // Memory strobes vanish while reset is held, even mid-access
   assign mem_req  = req_raw && reset;
   assign memwrite = wr_raw && reset;
   assign state    = STATE_W'(cur);

endmodule

// File: tb/tb_risc_mc_ctrl.sv
// Randomized self-checking bench for risc_mc_ctrl.
// Expected behaviour built per instruction from its cycle plan.
module tb_risc_mc_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] op;
   logic       compare;
   logic       mem_ready;
   logic       pcen, memwrite, irwrite, regwrite;
   logic       alusrca, iord, memtoreg, regdst;
   logic [1:0] alusrcb, pcsrc, alucontrol;
   logic       mem_req;
   logic [4:0] state;
   logic       illegal;
   logic [3:0] instret;

   int total  = 0;
   int passed = 0;
   int exp_ret = 0;
   int exp_ill = 0;

   logic [3:0] ops [7] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9};

   risc_mc_ctrl #(.CNT_W(4), .WAIT_MAX(15), .STATE_W(5)) dut (
      .clk(clk), .reset(reset), .op(op), .compare(compare),
      .mem_ready(mem_ready), .pcen(pcen), .memwrite(memwrite),
      .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca),
      .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
      .mem_req(mem_req), .state(state), .illegal(illegal),
      .instret(instret)
   );

   always #5 clk = ~clk;

   wire [14:0] outs = {pcen, memwrite, irwrite, regwrite, alusrca, iord,
                       memtoreg, regdst, alusrcb, pcsrc, alucontrol, mem_req};

   // {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,
   //  alusrcb,pcsrc,alucontrol,mem_req}
   function automatic logic [14:0] exp_out(input int code, input logic mr);
      logic [14:0] v;
      v = '0;
      case (code)
         0: begin
            v[0] = 1'b1; v[6:5] = 2'b01;
            if (mr) begin v[14] = 1'b1; v[12] = 1'b1; end
         end
         1: v[6:5] = 2'b11;
         2: begin
            v[10] = 1'b1;
            v[2:1] = (op == 4'h1) ? 2'b01 : (op == 4'h2) ? 2'b10 : 2'b00;
         end
         3: begin v[7] = 1'b1; v[11] = 1'b1; end
         4: begin v[10] = 1'b1; v[6:5] = 2'b10; end
         5: begin v[0] = 1'b1; v[9] = 1'b1; end
         6: begin v[8] = 1'b1; v[11] = 1'b1; end
         7: begin v[0] = 1'b1; v[9] = 1'b1; v[13] = 1'b1; end
         8: begin
            v[10] = 1'b1; v[2:1] = 2'b01; v[4:3] = 2'b01; v[14] = compare;
         end
         9: begin v[4:3] = 2'b10; v[14] = 1'b1; end
         default: v = '0;
      endcase
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One clock of the plan: check the state's outputs, then advance
   task automatic cyc(input int code, input logic mr, input bit ret,
                      input bit trp);
      mem_ready = mr;
      @(negedge clk);
      chk("state", 32'(state), 32'(code));
      chk("outs", 32'(outs), 32'(exp_out(code, mr)));
      chk("instret", 32'(instret), 32'(exp_ret % 16));
      chk("illegal", 32'(illegal), 32'(exp_ill));
      @(posedge clk);
      #1;
      if (ret) exp_ret++;
      if (trp) exp_ill = 1;
   endtask

   task automatic reset_pulse();
      #2 reset = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_memwrite", 32'(memwrite), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_instret", 32'(instret), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_hold", 32'(state), 32'd0);
      reset = 1'b1;
      exp_ret = 0;
      exp_ill = 0;
   endtask

   task automatic run_instr(input logic [3:0] o, input logic c,
                            input int wf, input int wm);
      bit bad;
      op = o;
      compare = c;
      bad = !(o inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9});
      for (int i = 0; i < wf; i++) cyc(0, 1'b0, 0, 0);
      cyc(0, 1'b1, 0, 0);
      cyc(1, 1'($urandom), 0, bad);
      case (o)
         4'h0, 4'h1, 4'h2: begin
            cyc(2, 1'($urandom), 0, 0);
            cyc(3, 1'($urandom), 1, 0);
         end
         4'h4: begin
            cyc(4, 1'($urandom), 0, 0);
            for (int i = 0; i < wm; i++) cyc(5, 1'b0, 0, 0);
            cyc(5, 1'b1, 0, 0);
            cyc(6, 1'($urandom), 1, 0);
         end
         4'h5: begin
            cyc(4, 1'($urandom), 0, 0);
            for (int i = 0; i < wm; i++) cyc(7, 1'b0, 0, 0);
            cyc(7, 1'b1, 1, 0);
         end
         4'h8: cyc(8, 1'($urandom), 1, 0);
         4'h9: cyc(9, 1'($urandom), 1, 0);
         default: begin
            for (int i = 0; i < 3; i++) cyc(10, 1'($urandom), 0, 0);
            reset_pulse();
         end
      endcase
   endtask

   initial begin
      logic [3:0] o;
      reset = 1'b0;
      op = 4'h0;
      compare = 1'b0;
      mem_ready = 1'b0;
      #3;
      chk("init_state", 32'(state), 32'd0);
      chk("init_illegal", 32'(illegal), 32'd0);
      chk("init_instret", 32'(instret), 32'd0);
      chk("init_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      run_instr(4'h0, 1'b0, 0, 0);
      run_instr(4'h4, 1'b0, 0, 3);
      run_instr(4'h8, 1'b1, 0, 0);
      run_instr(4'h8, 1'b0, 1, 0);
      run_instr(4'h1, 1'b0, 2, 0);
      run_instr(4'h2, 1'b1, 0, 0);
      run_instr(4'h5, 1'b0, 1, 2);
      for (int i = 0; i < 16; i++) run_instr(4'h9, 1'b0, 0, 0);
      run_instr(4'hF, 1'b0, 0, 0);

      op = 4'h5;
      cyc(0, 1'b1, 0, 0);
      cyc(1, 1'b0, 0, 0);
      cyc(4, 1'b0, 0, 0);
      cyc(7, 1'b0, 0, 0);
      reset_pulse();

`ifdef RISC_MC_TIMEOUT_EN
      op = 4'h9;
      for (int i = 0; i < 14; i++) cyc(0, 1'b0, 0, 0);
      cyc(0, 1'b0, 0, 1);
      cyc(10, 1'b1, 0, 0);
      cyc(10, 1'b0, 0, 0);
      reset_pulse();
`else
      run_instr(4'h9, 1'b0, 40, 0);
`endif

      for (int n = 0; n < 120; n++) begin
         o = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 19) == 0) o = 4'($urandom_range(10, 15));
         run_instr(o, 1'($urandom), $urandom_range(0, 4),
                   $urandom_range(0, 4));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/risc_mc_ctrl.md
RISC_MC_CTRL -- requirements
Module: risc_mc_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of retired-instruction counter instret.
REQ-002 Parameter WAIT_MAX, default 15: max wait cycles per memory access before timeout (timeout only when RISC_MC_TIMEOUT_EN is defined).
REQ-003 Parameter STATE_W, default 5: width of state output; SHALL be >= 4.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port reset  input  1: asynchronous, active-low reset.
REQ-006 Port op  input  4: instruction opcode from IR.
REQ-007 Port compare  input  1: ALU operands-equal flag from datapath.
REQ-008 Port mem_ready  input  1: memory access complete this cycle.
REQ-009 Ports pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst  output  1 each: datapath strobes/selects.
REQ-010 Ports alusrcb, pcsrc, alucontrol  output  2 each: datapath mux selects / ALU op (00 add, 01 sub, 10 nand).
REQ-011 Port mem_req  output  1: memory access in progress.
REQ-012 Port state  output  STATE_W: current FSM state code, zero-extended.
REQ-013 Port illegal  output  1: sticky flag, undefined opcode or timeout seen.
REQ-014 Port instret  output  CNT_W: retired-instruction count.

Function
REQ-015 States/codes: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, MEMADR=4, MEMRD=5, MEMWB=6, MEMWR=7, BRANCH=8, JUMP=9, TRAP=10.
REQ-016 Opcodes: 0000 ADD, 0001 SUB, 0010 NAND, 0100 LW, 0101 SW, 1000 BEQ, 1001 JMP; all others undefined.
REQ-017 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=00, pcsrc=00; on mem_ready irwrite=1, pcen=1, next DECODE; else stay.
REQ-018 DECODE: alusrca=0, alusrcb=11, alucontrol=00; next EXEC_R (ADD/SUB/NAND), MEMADR (LW/SW), BRANCH, JUMP, or TRAP (undefined, sets illegal).
REQ-019 EXEC_R: alusrca=1, alusrcb=00, alucontrol per op; next WB_R.
REQ-020 WB_R: regdst=1, memtoreg=0, regwrite=1; instret increments; next FETCH.
REQ-021 MEMADR: alusrca=1, alusrcb=10, alucontrol=00; next MEMRD (LW) or MEMWR (SW).
REQ-022 MEMRD: mem_req=1, iord=1; on mem_ready next MEMWB, else stay.
REQ-023 MEMWB: regdst=0, memtoreg=1, regwrite=1; instret increments; next FETCH.
REQ-024 MEMWR: mem_req=1, iord=1, memwrite=1 held until mem_ready; then instret increments, next FETCH.
REQ-025 BRANCH: alusrca=1, alusrcb=00, alucontrol=01, pcsrc=01; pcen=compare; instret increments; next FETCH.
REQ-026 JUMP: pcsrc=10, pcen=1; instret increments; next FETCH.
REQ-027 TRAP: absorbing; all strobes 0, mem_req=0; exit only via reset.
REQ-028 Outputs not listed for a state SHALL be 0; all outputs except state/illegal/instret are combinational from state, op, compare, mem_ready.
REQ-029 instret wraps modulo 2^CNT_W, no saturation.
REQ-030 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.

Reset
REQ-031 reset low: state=FETCH, illegal=0, instret=0, wait counter=0, immediately and asynchronously; released state begins fetch on first rising edge after reset high.
REQ-032 Reset mid-access SHALL drop mem_req/memwrite combinationally in the same cycle the state is forced to FETCH... FETCH re-asserts mem_req with iord=0, memwrite=0.

Configuration
REQ-033 Macro RISC_MC_TIMEOUT_EN defined: wait counter counts cycles in FETCH/MEMRD/MEMWR with mem_ready=0; reaching WAIT_MAX without mem_ready -> TRAP, illegal=1; counter clears on any state change.
REQ-034 Macro undefined: no wait counter; wait states are unbounded; illegal set only by undefined opcode.

Verification
REQ-035 ADD (op=0000), mem_ready=1 always -> states 0,1,2,3,0; regwrite=1 only in WB_R; instret 0->1.
REQ-036 LW with mem_ready low 3 cycles in MEMRD -> state holds 5 for 3 cycles, iord=1 throughout, then 6, regwrite=1, memtoreg=1.
REQ-037 BEQ with compare=1 then compare=0 -> pcen=1 with pcsrc=01 in first BRANCH, pcen=0 in second; instret +2.
REQ-038 op=1111 -> DECODE to TRAP (state=10), illegal=1, stays until reset low.
REQ-039 RISC_MC_TIMEOUT_EN, WAIT_MAX=15, mem_ready held 0 in FETCH -> TRAP after 15 cycles, illegal=1; without macro, stays FETCH indefinitely.
REQ-040 CNT_W=4, 16 retired JMPs -> instret wraps to 0; reset asserted during MEMWR -> memwrite=0 and state=0 immediately.
